esop_tt_sweeper: RTL and testbench

ESOP_TT_SWEEPER -- requirements
Module: esop_tt_sweeper

---
 rtl/esop_pkg.sv | 16 +
 rtl/esop_tt_sweeper_if.sv | 36 +++
 rtl/esop_mis_tracker.sv | 37 +++
 rtl/esop_tt_sweeper.sv | 93 +++++++++
 tb/tb_esop_tt_sweeper.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/esop_pkg.sv
// Shared definitions for the ESOP truth-table sweeper.
//   state_t  : sweeper FSM states (IDLE -> SWEEP -> DONE -> IDLE)
//   tt_width : truth-table width for a given number of ESOP inputs
package esop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/esop_tt_sweeper_if.sv
// Control/result bundle of the sweeper.
//   start     : request pulse, sampled only while the sweeper is idle
//   exp_tt    : expected truth table, captured together with an accepted start
//   busy      : high while sweeping
//   done      : one-cycle pulse when tt/ones/match/first_mis become valid
//   tt, ones, match, first_mis : results, held until the next accepted start
// Handshake: start is a level request; it is accepted on any rising edge where
// the sweeper is idle (busy=0 and done=0). While busy or done, start is ignored
// and nothing is queued. Results are valid from the done cycle until the edge
// that accepts the next start.
interface esop_tt_sweeper_if
  import esop_pkg::*;
#(
  parameter int N_IN = 8
);
  localparam int TT_W = tt_width(N_IN);

  logic              start;
  logic [TT_W-1:0]   exp_tt;
  logic              busy;
  logic              done;
  logic [TT_W-1:0]   tt;
  logic [N_IN:0]     ones;
  logic              match;
  logic [N_IN-1:0]   first_mis;

  modport master (
    output start, exp_tt,
    input  busy, done, tt, ones, match, first_mis
  );

  modport slave (
    input  start, exp_tt,
    output busy, done, tt, ones, match, first_mis
  );
endinterface

// File: rtl/esop_mis_tracker.sv
// Remembers whether any sampled output disagreed with the expected value and
// the index of the first disagreement.
//   clk, rst_n : clock, async active-low reset
//   clear      : start of a new sweep; wins over sample
//   sample     : a sweep sample is being taken this cycle
//   mis        : sampled output differs from expected bit
//   idx        : index of the current sample
//   seen       : a mismatch has been recorded since the last clear
//   first_mis  : index of the first mismatch (0 if none)
module esop_mis_tracker #(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            sample,
  input  logic            mis,
  input  logic [N_IN-1:0] idx,
  output logic            seen,
  output logic [N_IN-1:0] first_mis
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= 1'b0;
      first_mis <= '0;
    end else if (clear) begin
      seen      <= 1'b0;
      first_mis <= '0;
    end else if (sample && mis && !seen) begin
      // Only the lowest index is kept; the sweep visits indices in order.
      seen      <= 1'b1;
      first_mis <= idx;
    end
  end

endmodule

// File: rtl/esop_tt_sweeper.sv
// Drives every input vector into an external combinational ESOP block, one per
// cycle, capturing its output into a truth table and comparing against an
// expected table.
//   clk, rst_n : clock, async active-low reset
//   bus        : control/results (see esop_tt_sweeper_if)
//   x          : input vector to the ESOP block (bit 0 = x0)
//   o          : ESOP output for the current x, sampled on the edge that advances x
//   dbg_state  : current FSM state
module esop_tt_sweeper
  import esop_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  esop_tt_sweeper_if.slave  bus,
  output logic [N_IN-1:0]   x,
  input  logic              o,
  output state_t            dbg_state
);

  localparam int TT_W = tt_width(N_IN);

  state_t            state;
  state_t            state_nx;
  logic [TT_W-1:0]   exp_q;
  logic [TT_W-1:0]   tt_q;
  logic [N_IN:0]     ones_q;
  logic              seen;
  logic [N_IN-1:0]   first_mis_q;
  logic              accept;
  logic              sampling;
  logic              last;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign sampling = (state == ST_SWEEP);
  // x counts 0..TT_W-1, so the final vector is the all-ones value.
  assign last     = &x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_SWEEP;
      ST_SWEEP: if (last)      state_nx = ST_DONE;
      ST_DONE:                 state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      exp_q  <= '0;
      tt_q   <= '0;
      ones_q <= '0;
    end else if (accept) begin
      x      <= '0;
      exp_q  <= bus.exp_tt;
      tt_q   <= '0;
      ones_q <= '0;
    end else if (sampling) begin
      tt_q[x] <= o;
      ones_q  <= ones_q + {{N_IN{1'b0}}, o};
      // Natural N_IN-bit wrap brings x back to 0 after the last vector.
      x       <= x + 1'b1;
    end
  end

  esop_mis_tracker #(.N_IN(N_IN)) u_mis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .sample    (sampling),
    .mis       (o != exp_q[x]),
    .idx       (x),
    .seen      (seen),
    .first_mis (first_mis_q)
  );

  assign bus.busy      = (state == ST_SWEEP);
  assign bus.done      = (state == ST_DONE);
  assign bus.tt        = tt_q;
  assign bus.ones      = ones_q;
  assign bus.match     = ~seen;
  assign bus.first_mis = first_mis_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_esop_tt_sweeper.sv
// Directed bench for esop_tt_sweeper: an 8-input instance and a 3-input
// instance, each driving a small combinational ESOP model.
module tb_esop_tt_sweeper;
  import esop_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and ESOP models ----------------
  esop_tt_sweeper_if #(.N_IN(8)) bus8();
  esop_tt_sweeper_if #(.N_IN(3)) bus3();

  logic [7:0] x8;
  logic       o8;
  state_t     st8;
  logic [2:0] x3;
  logic       o3;
  state_t     st3;
  logic [1:0] mode8;

  always_comb begin
    o8 = 1'b0;
    if (mode8 == 2'd1) o8 = ~x8[5];
  end
  assign o3 = x3[0] & x3[1];

  esop_tt_sweeper #(.N_IN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .x(x8), .o(o8), .dbg_state(st8)
  );
  esop_tt_sweeper #(.N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .x(x3), .o(o3), .dbg_state(st3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep8(input logic [255:0] e);
    bus8.exp_tt = e;
    bus8.start  = 1'b1;
    tick();
    bus8.start  = 1'b0;
  endtask

  // Counts edges until done shows; n0 edges already elapsed since the accepting edge.
  task automatic wait_done8(input int n0, output int n);
    n = n0;
    while (bus8.done !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done3(output int n);
    n = 0;
    while (bus3.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  logic [255:0] e_x5c;
  logic [255:0] e_bad;
  int n;
  int dones;
  int first_done;
  logic busy_258;
  logic busy_259;

  // ---------------- stimulus ----------------
  initial begin
    mode8 = 2'd0;
    bus8.start = 1'b0; bus8.exp_tt = '0;
    bus3.start = 1'b0; bus3.exp_tt = '0;
    for (int i = 0; i < 256; i++) e_x5c[i] = (((i >> 5) & 1) == 0);
    e_bad = e_x5c;
    e_bad[37]  = ~e_bad[37];
    e_bad[200] = ~e_bad[200];

    // Reset state
    tick(); tick();
    check("rst_busy", 256'(bus8.busy), 256'(0));
    check("rst_done", 256'(bus8.done), 256'(0));
    check("rst_x", 256'(x8), 256'(0));
    check("rst_tt", bus8.tt, 256'(0));
    check("rst_ones", 256'(bus8.ones), 256'(0));
    check("rst_match", 256'(bus8.match), 256'(1));
    check("rst_first_mis", 256'(bus8.first_mis), 256'(0));
    check("rst_state", 256'(st8), 256'(ST_IDLE));
    check("rst3_match", 256'(bus3.match), 256'(1));
    rst_n = 1'b1;
    tick();

    // o tied 0, exp 0: done TT_W edges after the accepting edge
    mode8 = 2'd0;
    start_sweep8(256'(0));
    check("z_busy", 256'(bus8.busy), 256'(1));
    check("z_x0", 256'(x8), 256'(0));
    tick();
    check("z_x1", 256'(x8), 256'(1));
    wait_done8(1, n);
    check("z_latency", 256'(n), 256'(256));
    check("z_state_done", 256'(st8), 256'(ST_DONE));
    check("z_busy_done", 256'(bus8.busy), 256'(0));
    check("z_tt", bus8.tt, 256'(0));
    check("z_ones", 256'(bus8.ones), 256'(0));
    check("z_match", 256'(bus8.match), 256'(1));
    check("z_first_mis", 256'(bus8.first_mis), 256'(0));
    check("z_x_wrap", 256'(x8), 256'(0));
    // start while in DONE is dropped
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    check("z_done_pulse", 256'(bus8.done), 256'(0));
    tick();
    check("z_no_queue", 256'(bus8.busy), 256'(0));
    check("z_hold_match", 256'(bus8.match), 256'(1));

    // o = ~x5, expected matches
    mode8 = 2'd1;
    exp_q.push_back(e_x5c);
    start_sweep8(e_x5c);
    wait_done8(0, n);
    check("x5_latency", 256'(n), 256'(256));
    check("x5_tt", bus8.tt, exp_q.pop_front());
    check("x5_ones", 256'(bus8.ones), 256'(128));
    check("x5_match", 256'(bus8.match), 256'(1));
    check("x5_first_mis", 256'(bus8.first_mis), 256'(0));
    tick();

    // bits 37 and 200 flipped; a start mid-sweep must not re-latch exp_tt
    exp_q.push_back(e_x5c);
    start_sweep8(e_bad);
    for (int i = 0; i < 50; i++) tick();
    bus8.exp_tt = '0;
    bus8.start  = 1'b1;
    tick();
    bus8.start  = 1'b0;
    wait_done8(51, n);
    check("bad_latency", 256'(n), 256'(256));
    check("bad_tt", bus8.tt, exp_q.pop_front());
    check("bad_ones", 256'(bus8.ones), 256'(128));
    check("bad_match", 256'(bus8.match), 256'(0));
    check("bad_first_mis", 256'(bus8.first_mis), 256'(37));
    tick(); tick();
    check("bad_hold_match", 256'(bus8.match), 256'(0));
    check("bad_hold_first", 256'(bus8.first_mis), 256'(37));

    // Reset in the middle of a sweep
    start_sweep8(e_x5c);
    for (int i = 0; i < 99; i++) tick();
    check("mid_busy", 256'(bus8.busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 256'(bus8.busy), 256'(0));
    check("mid_rst_x", 256'(x8), 256'(0));
    check("mid_rst_tt", bus8.tt, 256'(0));
    check("mid_rst_ones", 256'(bus8.ones), 256'(0));
    check("mid_rst_match", 256'(bus8.match), 256'(1));
    check("mid_rst_first", 256'(bus8.first_mis), 256'(0));
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus8.done === 1'b1) dones++;
    end
    check("mid_no_done", 256'(dones), 256'(0));
    start_sweep8(e_bad);
    wait_done8(0, n);
    check("mid_restart_lat", 256'(n), 256'(256));
    check("mid_restart_first", 256'(bus8.first_mis), 256'(37));
    tick();

    // start held high for 300 edges
    mode8 = 2'd0;
    bus8.exp_tt = '0;
    bus8.start  = 1'b1;
    dones = 0; first_done = 0; busy_258 = 1'bx; busy_259 = 1'bx;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus8.done === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = i;
      end
      if (i == 258) busy_258 = bus8.busy;
      if (i == 259) busy_259 = bus8.busy;
    end
    bus8.start = 1'b0;
    check("hold_dones", 256'(dones), 256'(1));
    check("hold_first_done", 256'(first_done), 256'(257));
    check("hold_idle_gap", 256'(busy_258), 256'(0));
    check("hold_rearm", 256'(busy_259), 256'(1));
    // second sweep was accepted at edge 259, so done at edge 515
    wait_done8(300, n);
    check("hold_second_done", 256'(n), 256'(515));
    tick();

    // 3-input instance, o = x0 & x1
    bus3.exp_tt = 8'b1000_1000;
    bus3.start  = 1'b1;
    tick();
    bus3.start  = 1'b0;
    wait_done3(n);
    check("n3_latency", 256'(n), 256'(8));
    check("n3_tt", 256'(bus3.tt), 256'(8'b1000_1000));
    check("n3_ones", 256'(bus3.ones), 256'(2));
    check("n3_match", 256'(bus3.match), 256'(1));
    tick();
    bus3.exp_tt = 8'b1000_0000;
    bus3.start  = 1'b1;
    tick();
    bus3.start  = 1'b0;
    wait_done3(n);
    check("n3_mis_match", 256'(bus3.match), 256'(0));
    check("n3_mis_first", 256'(bus3.first_mis), 256'(3));
    check("n3_mis_ones", 256'(bus3.ones), 256'(2));
    tick();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
